// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: sequencer state encoding
// and the default operand width used by both control and datapath.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int MULT_STEPS = 8;

endpackage

// File: rtl/mult_step_sequencer.sv
// Iteration sequencer for the shift-add multiplier. It counts the remaining
// iterations down and the bit index up, supports a runtime length with abort,
// and provides busy/last/done handshakes to the multiplier controller.
module mult_step_sequencer
    import mult_pkg::*;
#(
    parameter int STEPS = MULT_STEPS,
    parameter int CNT_W = $clog2(STEPS) + 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             step,
    input  logic             abort,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] index,
    output logic             busy,
    output logic             last,
    output logic             done
);

    localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic             done_q,  done_d;

    // Effective length: zero or anything beyond the operand width means a
    // full-width operation. The compare is done at CNT_W bits.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] req);
        if (req == '0 || req > STEPS_C) begin
            return STEPS_C;
        end
        return req;
    endfunction

    // Next-state and counter update for the IDLE/RUN/DONE control FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = eff_len(len) - ONE_C;
                    index_d = '0;
                end
            end

            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                    index_d = '0;
                end else if (step) begin
                    if (count_q == '0) begin
                        // Final iteration: counters freeze so index keeps L-1.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q - ONE_C;
                        index_d = index_q + ONE_C;
                    end
                end
            end

            DONE: begin
                // Back-to-back start skips IDLE; abort here just cancels it.
                if (start && !abort) begin
                    state_d = RUN;
                    count_d = eff_len(len) - ONE_C;
                    index_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, matching real flops.
        if (!n_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode from registers only; no input reaches them combinationally.
    always_comb begin
        busy  = (state_q == RUN);
        last  = (state_q == RUN) && (count_q == '0);
        count = count_q;
        index = index_q;
        done  = done_q;
    end

endmodule

// File: tb/tb_mult_step_sequencer.sv
// Directed bench for mult_step_sequencer with STEPS=8. Each cycle pushes the
// expected post-edge outputs into a scoreboard queue; they are popped and
// compared one time unit after the edge. Key points also get constant checks.
module tb_mult_step_sequencer;

    localparam int STEPS = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             n_reset;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             step;
    logic             abort;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] index;
    logic             busy;
    logic             last;
    logic             done;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] index;
        logic             busy;
        logic             last;
        logic             done;
    } obs_t;

    obs_t exp_q[$];

    int total;
    int bad;

    // Reference model state: 0 = idle, 1 = run, 2 = done.
    int m_state;
    int m_cnt;
    int m_idx;
    int m_done;

    mult_step_sequencer #(
        .STEPS (STEPS),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start),
        .len     (len),
        .step    (step),
        .abort   (abort),
        .count   (count),
        .index   (index),
        .busy    (busy),
        .last    (last),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one rising edge with the given inputs.
    task automatic model_edge(input logic r, input logic st, input logic [CNT_W-1:0] ln,
                              input logic sp, input logic ab);
        int l_eff;
        l_eff = (ln == 0 || int'(ln) > STEPS) ? STEPS : int'(ln);
        if (!r) begin
            m_state = 0; m_cnt = 0; m_idx = 0; m_done = 0;
        end else begin
            case (m_state)
                0: begin
                    m_done = 0;
                    if (st) begin m_state = 1; m_cnt = l_eff - 1; m_idx = 0; end
                end
                1: begin
                    m_done = 0;
                    if (ab) begin
                        m_state = 0; m_cnt = 0; m_idx = 0;
                    end else if (sp && m_cnt == 0) begin
                        m_state = 2; m_done = 1;
                    end else if (sp) begin
                        m_cnt = m_cnt - 1; m_idx = m_idx + 1;
                    end
                end
                default: begin
                    m_done = 0;
                    if (st && !ab) begin m_state = 1; m_cnt = l_eff - 1; m_idx = 0; end
                    else m_state = 0;
                end
            endcase
        end
    endtask

    // One clock: drive inputs at the falling edge, record the expectation,
    // then compare the popped expectation just after the rising edge.
    task automatic cyc(input logic r, input logic st, input logic [CNT_W-1:0] ln,
                       input logic sp, input logic ab);
        obs_t e;
        @(negedge clk);
        n_reset = r; start = st; len = ln; step = sp; abort = ab;
        model_edge(r, st, ln, sp, ab);
        e.count = CNT_W'(m_cnt);
        e.index = CNT_W'(m_idx);
        e.busy  = (m_state == 1);
        e.last  = (m_state == 1) && (m_cnt == 0);
        e.done  = (m_done != 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_count", 32'(count), 32'(e.count));
            check("sb_index", 32'(index), 32'(e.index));
            check("sb_busy",  32'(busy),  32'(e.busy));
            check("sb_last",  32'(last),  32'(e.last));
            check("sb_done",  32'(done),  32'(e.done));
        end
    endtask

    initial begin
        total = 0; bad = 0;
        m_state = 0; m_cnt = 0; m_idx = 0; m_done = 0;
        n_reset = 1'b0; start = 1'b0; len = '0; step = 1'b0; abort = 1'b0;

        // Reset for two cycles.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        check("rst_count", 32'(count), 0);
        check("rst_busy",  32'(busy),  0);
        check("rst_done",  32'(done),  0);

        // Default length (len=0 -> 8) with step held high.
        cyc(1, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            check("full_count", 32'(count), 32'(7 - i));
            check("full_index", 32'(index), 32'(i));
            check("full_last",  32'(last),  32'(i == 7));
            check("full_busy",  32'(busy),  1);
            check("full_done",  32'(done),  0);
            cyc(1, 0, 0, 1, 0);
        end
        check("full_done_pulse", 32'(done),  1);
        check("full_done_busy",  32'(busy),  0);
        check("full_done_index", 32'(index), 7);
        cyc(1, 0, 0, 0, 0);
        check("full_done_clear", 32'(done),  0);
        check("idle_index_hold", 32'(index), 7);

        // Step in IDLE is ignored.
        cyc(1, 0, 0, 1, 0);
        check("idle_step_count", 32'(count), 0);
        check("idle_step_index", 32'(index), 7);

        // Short length 3.
        cyc(1, 1, 3, 1, 0);
        check("len3_first", 32'(count), 2);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0);
        check("len3_done", 32'(done), 1);
        cyc(1, 0, 0, 0, 0);

        // Length 12 clamps to 8.
        cyc(1, 1, 12, 1, 0);
        check("len12_first", 32'(count), 7);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 0);
        check("len12_done", 32'(done), 1);
        cyc(1, 0, 0, 0, 0);

        // Length 1: last on the first RUN cycle, done after one step.
        cyc(1, 1, 1, 0, 0);
        check("len1_last",  32'(last),  1);
        check("len1_count", 32'(count), 0);
        cyc(1, 0, 0, 1, 0);
        check("len1_done",  32'(done),  1);
        cyc(1, 0, 0, 0, 0);

        // Stall: count moves only on step cycles; then abort+step at count=4.
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        check("stall_hold", 32'(count), 6);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        check("stall_count4", 32'(count), 4);
        cyc(1, 0, 0, 1, 1);
        check("abort_count", 32'(count), 0);
        check("abort_index", 32'(index), 0);
        check("abort_busy",  32'(busy),  0);
        check("abort_done",  32'(done),  0);
        cyc(1, 0, 0, 0, 0);
        check("abort_no_done", 32'(done), 0);

        // Back-to-back: start during DONE goes straight to RUN.
        cyc(1, 1, 2, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        check("b2b_done", 32'(done), 1);
        cyc(1, 1, 3, 1, 0);
        check("b2b_busy",  32'(busy),  1);
        check("b2b_count", 32'(count), 2);
        check("b2b_index", 32'(index), 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0);
        check("b2b_done2", 32'(done), 1);
        cyc(1, 0, 0, 0, 0);

        // Mid-operation reset at count=5.
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        check("midrst_pre", 32'(count), 5);
        cyc(0, 0, 0, 1, 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_busy",  32'(busy),  0);
        cyc(1, 0, 0, 0, 0);

        // Start while in RUN does not reload.
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 3, 0, 0);
        check("run_start_ignored", 32'(count), 6);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
